// File: rtl/bcd_mod_timer.sv
// bcd_mod_timer: two-digit BCD modulo-MODULUS up/down timer with checked
// synchronous preload and a combinational terminal count for cascading
// (seconds -> minutes -> hours).
// Optional build macro: BCD_TIMER_ALARM_EN adds alarm_low/alarm_high/
// alarm_ack inputs and a sticky alarm output.
module bcd_mod_timer #(
    parameter int MODULUS = 60,
    parameter int HI_W    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            dir,
    input  logic            load,
    input  logic [3:0]      load_low,
    input  logic [HI_W-1:0] load_high,
    output logic [3:0]      low_digit,
    output logic [HI_W-1:0] high_digit,
    output logic            tc,
    output logic            load_err
`ifdef BCD_TIMER_ALARM_EN
    ,
    input  logic [3:0]      alarm_low,
    input  logic [HI_W-1:0] alarm_high,
    input  logic            alarm_ack,
    output logic            alarm
`endif
);

    // Digits of the top count value MODULUS-1 (target of the down wrap).
    localparam logic [HI_W-1:0] TOP_HI = HI_W'((MODULUS - 1) / 10);
    localparam logic [3:0]      TOP_LO = 4'((MODULUS - 1) % 10);
    localparam logic [7:0]      MAX_V  = 8'(MODULUS - 1);

    logic            at_max;
    logic            at_zero;
    logic [7:0]      load_v;
    logic            load_ok;
    logic [3:0]      nxt_low;
    logic [HI_W-1:0] nxt_high;
    logic            nxt_err;
    logic            moved;

    // Wrap detection compares the full value, so partial top digits work.
    assign at_max  = (high_digit == TOP_HI) && (low_digit == TOP_LO);
    assign at_zero = (high_digit == '0) && (low_digit == 4'd0);

    // A preload is accepted only if it is a legal BCD value below MODULUS.
    assign load_v  = 8'(load_high) * 8'd10 + 8'(load_low);
    assign load_ok = (load_low <= 4'd9) && (load_v <= MAX_V);

    // Terminal count is zero-latency so the next stage steps on the wrap edge.
    assign tc = enable & ((~dir & at_max) | (dir & at_zero));

    // Next-value selection: load beats count, count beats hold.
    always_comb begin
        nxt_low  = low_digit;
        nxt_high = high_digit;
        nxt_err  = 1'b0;
        moved    = 1'b0;
        if (load) begin
            if (load_ok) begin
                nxt_low  = load_low;
                nxt_high = load_high;
                moved    = 1'b1;
            end else begin
                nxt_err = 1'b1;
            end
        end else if (enable) begin
            moved = 1'b1;
            if (!dir) begin
                if (at_max) begin
                    nxt_low  = 4'd0;
                    nxt_high = '0;
                end else if (low_digit == 4'd9) begin
                    nxt_low  = 4'd0;
                    nxt_high = high_digit + HI_W'(1);
                end else begin
                    nxt_low = low_digit + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    nxt_low  = TOP_LO;
                    nxt_high = TOP_HI;
                end else if (low_digit == 4'd0) begin
                    nxt_low  = 4'd9;
                    nxt_high = high_digit - HI_W'(1);
                end else begin
                    nxt_low = low_digit - 4'd1;
                end
            end
        end
    end

    // Digit and error-pulse registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_digit  <= 4'd0;
            high_digit <= '0;
            load_err   <= 1'b0;
        end else begin
            low_digit  <= nxt_low;
            high_digit <= nxt_high;
            load_err   <= nxt_err;
        end
    end

`ifdef BCD_TIMER_ALARM_EN
    logic alarm_set;

    // Digit compare: an alarm value at or above MODULUS can never be reached.
    assign alarm_set = moved && (nxt_low == alarm_low) && (nxt_high == alarm_high);

    // Sticky alarm flag; a new match on the ack edge keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm <= 1'b0;
        end else if (alarm_set) begin
            alarm <= 1'b1;
        end else if (alarm_ack) begin
            alarm <= 1'b0;
        end
    end
`else
    logic unused_moved;
    assign unused_moved = moved;
`endif

endmodule

// File: tb/tb_bcd_mod_timer.sv
// tb_bcd_mod_timer: directed and random stimulus for bcd_mod_timer
// (mod-60 and mod-24 instances plus a seconds->minutes cascade), checked
// against an integer-arithmetic reference model.
// Build macro BCD_TIMER_ALARM_EN also exercises the alarm option.
module tb_bcd_mod_timer;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // mod-60 instance
    logic       r0 = 1'b0, e0 = 1'b0, d0 = 1'b0, l0 = 1'b0;
    logic [3:0] ll0 = '0;
    logic [2:0] lh0 = '0;
    logic [3:0] lo0;
    logic [2:0] hi0;
    logic       tc0, le0;

    // mod-24 instance
    logic       r1 = 1'b0, e1 = 1'b0, d1 = 1'b0, l1 = 1'b0;
    logic [3:0] ll1 = '0;
    logic [1:0] lh1 = '0;
    logic [3:0] lo1;
    logic [1:0] hi1;
    logic       tc1, le1;

    // cascade pair
    logic       cr = 1'b0, ce = 1'b0;
    logic [3:0] s_lo, m_lo;
    logic [2:0] s_hi, m_hi;
    logic       s_tc, m_tc, s_le, m_le;

`ifdef BCD_TIMER_ALARM_EN
    logic [3:0] al0 = 4'd5;
    logic [2:0] ah0 = 3'd4;
    logic       ack0 = 1'b0;
    logic       alm0, alm1, alm_s, alm_m;
    bit         malarm = 1'b0;
`endif

    // reference model state: plain integer value per instance
    int mv[2];
    bit merr[2];
    int mm[2];

    bcd_mod_timer #(.MODULUS(60), .HI_W(3)) u60 (
        .clk(clk), .reset(r0), .enable(e0), .dir(d0), .load(l0),
        .load_low(ll0), .load_high(lh0), .low_digit(lo0), .high_digit(hi0),
        .tc(tc0), .load_err(le0)
`ifdef BCD_TIMER_ALARM_EN
        , .alarm_low(al0), .alarm_high(ah0), .alarm_ack(ack0), .alarm(alm0)
`endif
    );

    bcd_mod_timer #(.MODULUS(24), .HI_W(2)) u24 (
        .clk(clk), .reset(r1), .enable(e1), .dir(d1), .load(l1),
        .load_low(ll1), .load_high(lh1), .low_digit(lo1), .high_digit(hi1),
        .tc(tc1), .load_err(le1)
`ifdef BCD_TIMER_ALARM_EN
        , .alarm_low(4'd0), .alarm_high(2'd0), .alarm_ack(1'b0), .alarm(alm1)
`endif
    );

    bcd_mod_timer #(.MODULUS(60), .HI_W(3)) u_sec (
        .clk(clk), .reset(cr), .enable(ce), .dir(1'b0), .load(1'b0),
        .load_low(4'd0), .load_high(3'd0), .low_digit(s_lo), .high_digit(s_hi),
        .tc(s_tc), .load_err(s_le)
`ifdef BCD_TIMER_ALARM_EN
        , .alarm_low(4'd0), .alarm_high(3'd0), .alarm_ack(1'b0), .alarm(alm_s)
`endif
    );

    bcd_mod_timer #(.MODULUS(60), .HI_W(3)) u_min (
        .clk(clk), .reset(cr), .enable(s_tc), .dir(1'b0), .load(1'b0),
        .load_low(4'd0), .load_high(3'd0), .low_digit(m_lo), .high_digit(m_hi),
        .tc(m_tc), .load_err(m_le)
`ifdef BCD_TIMER_ALARM_EN
        , .alarm_low(4'd0), .alarm_high(3'd0), .alarm_ack(1'b0), .alarm(alm_m)
`endif
    );

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clock of one instance ----------------
    task automatic step(input int k, input bit rst, input bit en, input bit dr,
                        input bit ld, input int lh, input int ll);
        int  m, v, lv;
        bit  mov, exp_tc;
        logic [3:0] olo, ohi;
        logic       otc, oerr;
        m = mm[k];
        v = mv[k];
        if (k == 0) begin
            r0 = rst; e0 = en; d0 = dr; l0 = ld; lh0 = 3'(lh); ll0 = 4'(ll);
        end else begin
            r1 = rst; e1 = en; d1 = dr; l1 = ld; lh1 = 2'(lh); ll1 = 4'(ll);
        end
        #1;
        otc = (k == 0) ? tc0 : tc1;
        exp_tc = en && (dr ? (v == 0) : (v == m - 1));
        chk($sformatf("tc%0d", m), 32'(otc), 32'(exp_tc));

        mov = 1'b0;
        if (rst) begin
            v = 0;
            merr[k] = 1'b0;
        end else if (ld) begin
            lv = 10 * lh + ll;
            if (ll <= 9 && lv < m) begin
                v = lv;
                mov = 1'b1;
                merr[k] = 1'b0;
            end else begin
                merr[k] = 1'b1;
            end
        end else begin
            merr[k] = 1'b0;
            if (en) begin
                v = dr ? (v + m - 1) % m : (v + 1) % m;
                mov = 1'b1;
            end
        end
`ifdef BCD_TIMER_ALARM_EN
        if (k == 0) begin
            if (rst) malarm = 1'b0;
            else if (mov && v / 10 == int'(ah0) && v % 10 == int'(al0)) malarm = 1'b1;
            else if (ack0) malarm = 1'b0;
        end
`endif
        mv[k] = v;

        @(posedge clk);
        #1;
        olo  = (k == 0) ? lo0 : lo1;
        ohi  = (k == 0) ? 4'(hi0) : 4'(hi1);
        oerr = (k == 0) ? le0 : le1;
        chk($sformatf("low%0d", m), 32'(olo), 32'(v % 10));
        chk($sformatf("high%0d", m), 32'(ohi), 32'(v / 10));
        chk($sformatf("load_err%0d", m), 32'(oerr), 32'(merr[k]));
`ifdef BCD_TIMER_ALARM_EN
        if (k == 0) chk("alarm", 32'(alm0), 32'(malarm));
`endif
        if (k == 0) begin
            r0 = 1'b0; e0 = 1'b0; l0 = 1'b0;
        end else begin
            r1 = 1'b0; e1 = 1'b0; l1 = 1'b0;
        end
    endtask

    // ---------------- directed sequence, random run, report ----------------
    initial begin
        int pulses;
        int k, lh, ll;
        bit rst, en, dr, ld;
        mm[0] = 60; mm[1] = 24;
        mv[0] = 0;  mv[1] = 0;
        merr[0] = 1'b0; merr[1] = 1'b0;

        // reset both instances twice; second cycle checks tc=enable at V=0, dir=1
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 0);

        // mod-60 up count through the wrap
        for (int i = 0; i < 61; i++) begin
            step(0, 0, 1, 0, 0, 0, 0);
            chk("high60_le5", 32'(hi0 <= 3'd5), 32'd1);
        end

        // mod-24 load 23, count down through the wrap, then flip to up at 23
        step(1, 0, 0, 0, 1, 2, 3);
        for (int i = 0; i < 24; i++) step(1, 0, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);

        // invalid loads keep digits and pulse load_err for one cycle
        step(0, 0, 0, 0, 1, 1, 7);
        step(0, 0, 0, 0, 1, 6, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 10);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 9);

        // simultaneous events at V=37
        step(0, 0, 0, 0, 1, 3, 7);
        step(0, 1, 1, 0, 1, 1, 2);
        step(0, 0, 0, 0, 1, 3, 7);
        step(0, 0, 1, 0, 1, 1, 2);
        step(0, 0, 0, 0, 1, 3, 7);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);

`ifdef BCD_TIMER_ALARM_EN
        // alarm at 45: rise, stick, ack clears, ack coincident with match keeps it
        ack0 = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        ack0 = 1'b0;
        step(0, 0, 0, 0, 1, 4, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0, 0);
        ack0 = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        ack0 = 1'b0;
        step(0, 0, 0, 0, 1, 4, 4);
        ack0 = 1'b1;
        step(0, 0, 1, 0, 0, 0, 0);
        ack0 = 1'b0;
`endif

        // random mix of reset, load, count and direction on both instances
        for (int i = 0; i < 600; i++) begin
            k   = int'($urandom_range(0, 1));
            rst = ($urandom_range(0, 31) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            en  = ($urandom_range(0, 3) != 0);
            dr  = 1'($urandom_range(0, 1));
            lh  = (k == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3));
            ll  = int'($urandom_range(0, 12));
`ifdef BCD_TIMER_ALARM_EN
            ack0 = ($urandom_range(0, 3) == 0);
`endif
            step(k, rst, en, dr, ld, lh, ll);
        end
`ifdef BCD_TIMER_ALARM_EN
        ack0 = 1'b0;
`endif

        // cascade: seconds tc drives minutes enable for one full hour
        cr = 1'b1;
        @(posedge clk);
        #1;
        cr = 1'b0;
        chk("casc_sec_reset", 32'(10 * s_hi + s_lo), 32'd0);
        chk("casc_min_reset", 32'(10 * m_hi + m_lo), 32'd0);
        ce = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 3600; i++) begin
            if (m_tc) pulses++;
            @(posedge clk);
            #1;
            chk("casc_sec", 32'(10 * s_hi + s_lo), 32'(i % 60));
            chk("casc_min", 32'(10 * m_hi + m_lo), 32'((i / 60) % 60));
        end
        ce = 1'b0;
        chk("casc_min_tc_pulses", 32'(pulses), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_mod_timer.md
Name: bcd_mod_timer

Overview:
- Parametrised two-digit BCD modulo-N timer. It generalises the fixed mod-60 seconds counter to any modulus from 2 to 100.
- Adds count direction, synchronous preload with range checking, and a cascade terminal-count output. Stages chain as seconds -> minutes -> hours: a mod-60 instance feeds a mod-60 instance, which feeds a mod-24 instance.

Parameters:
- MODULUS, 60, count range 0..MODULUS-1. Legal values 2..100.
- HI_W, 3, width of high_digit. Must hold (MODULUS-1)/10. For MODULUS=100, HI_W=4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count-advance qualifier. Driven by the previous stage's tc when cascaded.
- dir  in  1  0 = count up, 1 = count down.
- load  in  1  synchronous preload strobe.
- load_low  in  4  BCD low digit to preload.
- load_high  in  HI_W  BCD high digit to preload.
- low_digit  out  4  current units digit, BCD 0..9.
- high_digit  out  HI_W  current tens digit.
- tc  out  1  terminal count (combinational), for cascading.
- load_err  out  1  registered one-cycle pulse: last load was rejected.

Behaviour:
- Value V = 10*high_digit + low_digit. The invariant 0 <= V <= MODULUS-1 holds in every cycle after reset, and low_digit never exceeds 9.
- Reset: low_digit=0, high_digit=0, load_err=0. tc follows its equation: 0 when dir=0; when dir=1, tc=enable because V=0.
- Priority on each rising edge: reset > load > enable > hold.
- Load is valid when load_low <= 9 and 10*load_high + load_low <= MODULUS-1.
  - Valid load: digits take the load values next cycle; load_err=0.
  - Invalid load: digits are unchanged; load_err=1 for exactly one cycle.
  - load_err returns to 0 on the next edge unless another invalid load occurs.
- load with enable=1 in the same cycle: load wins and no count occurs that cycle. tc is still driven combinationally from the pre-load value.
- Up count (enable=1, dir=0):
  - low<9 and V != MODULUS-1: low+1.
  - low=9 and V != MODULUS-1: low=0, high+1.
  - V=MODULUS-1: low=0, high=0 (wrap).
- Down count (enable=1, dir=1):
  - low>0: low-1.
  - low=0 and V != 0: low=9, high-1.
  - V=0: V=MODULUS-1, i.e. high=(MODULUS-1)/10, low=(MODULUS-1)%10 (wrap).
- Non-multiple-of-10 moduli:
  - Up wrap triggers on the full value, not on low=9 (MODULUS=24: 23 -> 00).
  - Down wrap loads the partial top digit (MODULUS=24: 00 -> 23).
- tc = enable & ((dir=0 & V=MODULUS-1) | (dir=1 & V=0)).
  - Purely combinational, zero latency, so the next stage advances on the same edge as the wrap.
  - tc=0 whenever enable=0.
- dir may change on any cycle; it takes effect on the next enabled edge with no pipeline state.
- Reset mid-count forces 00 on that edge regardless of load or enable.
- Latency: count and load are both one cycle from input to output.

Optional Feature:
- Macro: BCD_TIMER_ALARM_EN.
- When defined, three ports are added:
  - alarm_low (in, 4) and alarm_high (in, HI_W): alarm value.
  - alarm (out, 1): sticky flag.
  - alarm_ack (in, 1): clears the flag.
- alarm sets on the edge where the next value equals {alarm_high, alarm_low}, through either count or load. It remains set until alarm_ack=1.
- If alarm_ack and a set condition occur on the same edge, set wins.
- reset clears alarm.
- An alarm value >= MODULUS never matches.
- When the macro is not defined, these ports and their logic do not exist and core behaviour is identical.

Test Plan:
- MODULUS=60; reset 2 cycles, then enable=1, dir=0 for 61 cycles:
  - sequence runs 00,01..09,10..59,00.
  - tc=1 only in the cycle V=59.
  - high_digit never exceeds 5.
- MODULUS=24; load 2/3, then dir=1, enable=1:
  - 23,22..20,19..00,23.
  - tc=1 only at V=00.
  - Then dir=0 at V=23: next value is 00.
- MODULUS=60; invalid loads 6/0 (V=60) and 3/A (low=10):
  - digits unchanged.
  - load_err=1 for exactly one cycle after each.
  - Valid load 5/9 gives 59 and load_err=0.
- Cascade: mod-60 seconds tc drives mod-60 minutes enable, from 00:00:
  - after 3600 clocks minutes=00 and seconds=00.
  - minutes tc pulses exactly once.
- Simultaneous events at V=37:
  - reset+load+enable -> 00.
  - load 1/2 + enable -> 12, not 13.
  - reset during a count run -> 00, counting resumes from 01 next enabled cycle.
- With BCD_TIMER_ALARM_EN and alarm value 4/5:
  - count up from 40; alarm rises on the edge reaching 45 and stays high through 46..
  - alarm_ack clears it.
  - ack coincident with the next match keeps it set.
